// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC scan sequencer.
// State encoding, bus widths, result payload and a lowest-set-bit helper.
package adc_pkg;

   localparam int unsigned ADC_W  = 12;
   localparam int unsigned CH_W   = 3;
   localparam int unsigned NUM_CH = 8;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      PUBLISH,
      NEXT,
      GAP
   } state_t;

   typedef struct packed {
      logic [CH_W-1:0]  ch;
      logic [ADC_W-1:0] data;
   } result_t;

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
      logic [CH_W-1:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) r = CH_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/adc_next_channel.sv
// Combinational priority finder: lowest set mask bit strictly above the current channel.
// No wrap; found is low when no higher channel is enabled.
module adc_next_channel
   import adc_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   cur,
   output logic [CH_W-1:0]   nxt,
   output logic              found
);

   always_comb begin
      nxt   = '0;
      found = 1'b0;
      // Descending walk so the lowest qualifying index is written last.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i] && (i > int'(cur))) begin
            nxt   = CH_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans enabled ADC channels, averages 2^AVG_LOG2 samples each, keeps the latest
// averaged result per channel in a bank and strobes each new result downstream.
module adc_scan_sequencer
   import adc_pkg::*;
#(
   parameter int unsigned AVG_LOG2 = 2,
   parameter int unsigned TIMEOUT  = 127,
   parameter int unsigned SCAN_GAP = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [NUM_CH-1:0] CH_MASK,
   output logic [CH_W-1:0]   ADC_ADDR,
   output logic              ADC_START,
   input  logic              ADC_BUSY,
   input  logic [ADC_W-1:0]  ADC_DATA,
   output logic              RES_VALID,
   output logic [CH_W-1:0]   RES_CH,
   output logic [ADC_W-1:0]  RES_DATA,
   output logic              SCAN_DONE,
   input  logic [CH_W-1:0]   RD_ADDR,
   output logic [ADC_W-1:0]  RD_DATA,
   output logic              ERR,
   output logic [CH_W-1:0]   ERR_CH,
   input  logic              ERR_CLR
);

   localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
   localparam int unsigned CNT_W = AVG_LOG2 + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam int unsigned GAP_W = (SCAN_GAP > 0) ? $clog2(SCAN_GAP + 1) : 1;
   localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(2 ** AVG_LOG2);

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] scan_mask_q, scan_mask_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic              start_q, start_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   result_t           res_q, res_d;
   logic              res_valid_q, res_valid_d;
   logic              scan_done_q, scan_done_d;
   logic              err_q, err_d;
   logic [CH_W-1:0]   err_ch_q, err_ch_d;
   logic              bank_we;
   logic [ADC_W-1:0]  bank [NUM_CH];

   logic [CH_W-1:0]   next_ch;
   logic              next_found;
   logic              tmo_hit;
   logic [CNT_W-1:0]  cnt_inc;

   adc_next_channel u_next (
      .mask  (scan_mask_q),
      .cur   (ch_q),
      .nxt   (next_ch),
      .found (next_found)
   );

   assign tmo_hit = (tmo_q >= TMO_W'(TIMEOUT - 1));
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      scan_mask_d = scan_mask_q;
      ch_d        = ch_q;
      start_d     = 1'b0;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      gap_d       = gap_q;
      res_d       = res_q;
      res_valid_d = 1'b0;
      scan_done_d = 1'b0;
      err_d       = err_q & ~ERR_CLR;
      err_ch_d    = err_ch_q;
      bank_we     = 1'b0;

      case (state_q)
         IDLE: begin
            acc_d = '0;
            cnt_d = '0;
            if (EN && (CH_MASK != '0)) begin
               scan_mask_d = CH_MASK;
               ch_d        = lowest_ch(CH_MASK);
               start_d     = 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            tmo_d   = '0;
            state_d = WAIT_ACK;
         end
         WAIT_ACK, WAIT_DONE: begin
            tmo_d = tmo_q + TMO_W'(1);
            if ((state_q == WAIT_ACK) && ADC_BUSY) begin
               state_d = WAIT_DONE;
            end else if ((state_q == WAIT_DONE) && !ADC_BUSY) begin
               if (!EN) begin
                  // Conversion finished after EN dropped: drop the partial average.
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  acc_d = acc_q + ACC_W'(ADC_DATA);
                  cnt_d = cnt_inc;
                  if (cnt_inc == N_SAMPLES) begin
                     state_d = PUBLISH;
                  end else begin
                     start_d = 1'b1;
                     state_d = ISSUE;
                  end
               end
            end else if (tmo_hit) begin
               err_d       = 1'b1;
               err_ch_d    = ch_q;
               acc_d       = '0;
               cnt_d       = '0;
               scan_done_d = !next_found && EN;
               state_d     = NEXT;
            end
         end
         PUBLISH: begin
            bank_we     = 1'b1;
            res_d.ch    = ch_q;
            res_d.data  = ADC_W'(acc_q >> AVG_LOG2);
            res_valid_d = 1'b1;
            scan_done_d = !next_found && EN;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = NEXT;
         end
         NEXT: begin
            gap_d = '0;
            if (!EN) begin
               state_d = IDLE;
            end else if (next_found) begin
               ch_d    = next_ch;
               start_d = 1'b1;
               state_d = ISSUE;
            end else begin
               state_d = (SCAN_GAP == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            gap_d = gap_q + GAP_W'(1);
            if (gap_q == GAP_W'(SCAN_GAP - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         scan_mask_q <= '0;
         ch_q        <= '0;
         start_q     <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         gap_q       <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         scan_done_q <= 1'b0;
         err_q       <= 1'b0;
         err_ch_q    <= '0;
         for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
      end else begin
         scan_mask_q <= scan_mask_d;
         ch_q        <= ch_d;
         start_q     <= start_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         gap_q       <= gap_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         scan_done_q <= scan_done_d;
         err_q       <= err_d;
         err_ch_q    <= err_ch_d;
         if (bank_we) bank[ch_q] <= res_d.data;
      end
   end

   assign ADC_ADDR  = ch_q;
   assign ADC_START = start_q;
   assign RES_VALID = res_valid_q;
   assign RES_CH    = res_q.ch;
   assign RES_DATA  = res_q.data;
   assign SCAN_DONE = scan_done_q;
   assign ERR       = err_q;
   assign ERR_CH    = err_ch_q;
   assign RD_DATA   = bank[RD_ADDR];

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench: four sequencers (AVG_LOG2 = 0, 2, 4, 1) share control inputs,
// each with its own behavioural converter model.
module tb_adc_scan_sequencer;

   localparam int unsigned TMO  = 40;
   localparam int unsigned CONV = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] ch_mask;
   logic       err_clr;
   logic [2:0] rd_addr;
   logic       stall;
   int         mode;
   int         tests = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   // Converter data: 0 = 12'h100+ch, 1 = 10,11,12,14 repeating, other = 12'hFFF.
   function automatic logic [11:0] gen_data(input int m, input logic [2:0] c, input int i);
      logic [11:0] v;
      case (m)
         0: v = 12'h100 + 12'(c);
         1: case (i % 4)
               0:       v = 12'd10;
               1:       v = 12'd11;
               2:       v = 12'd12;
               default: v = 12'd14;
            endcase
         default: v = 12'hFFF;
      endcase
      return v;
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int unsigned AL = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 4 : 1;
      logic [2:0]  addr, addr_l, rch, errch;
      logic        start, busy, rv, sd, err;
      logic [11:0] data, rdat, rdd;
      int          cnt, idx;
      int          sc [8];

      adc_scan_sequencer #(.AVG_LOG2(AL), .TIMEOUT(TMO), .SCAN_GAP(2)) u_dut (
         .CLK(clk), .RST(rst_n), .EN(en), .CH_MASK(ch_mask),
         .ADC_ADDR(addr), .ADC_START(start), .ADC_BUSY(busy), .ADC_DATA(data),
         .RES_VALID(rv), .RES_CH(rch), .RES_DATA(rdat), .SCAN_DONE(sd),
         .RD_ADDR(rd_addr), .RD_DATA(rdd), .ERR(err), .ERR_CH(errch), .ERR_CLR(err_clr)
      );

      // BUSY rises the cycle after START, stays high CONV cycles, DATA valid as it falls.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            busy   <= 1'b0;
            data   <= '0;
            addr_l <= '0;
            cnt    <= 0;
            idx    <= 0;
            for (int i = 0; i < 8; i++) sc[i] <= 0;
         end else begin
            if (start) sc[addr] <= sc[addr] + 1;
            if (busy) begin
               if (cnt == 0) begin
                  busy <= 1'b0;
                  data <= gen_data(mode, addr_l, idx);
                  idx  <= idx + 1;
               end else begin
                  cnt <= cnt - 1;
               end
            end else if (start && !stall) begin
               busy   <= 1'b1;
               cnt    <= CONV - 1;
               addr_l <= addr;
            end
         end
      end
   end

   task automatic do_reset(input logic [7:0] mask, input int m);
      rst_n = 1'b0; en = 1'b0; ch_mask = mask; err_clr = 1'b0;
      rd_addr = '0; stall = 1'b0; mode = m;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset(8'h00, 0);
      rst_n = 1'b0;
      @(negedge clk);
      tests++;
      if ({g_dut[0].addr, g_dut[0].start, g_dut[0].rv, g_dut[0].rch, g_dut[0].rdat,
           g_dut[0].sd, g_dut[0].err, g_dut[0].errch} !== '0)
         begin fails++; $display("FAIL reset_outputs: addr=%0d start=%b rv=%b rdat=%h err=%b expected all 0",
            g_dut[0].addr, g_dut[0].start, g_dut[0].rv, g_dut[0].rdat, g_dut[0].err); end
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a);
         #1;
         tests++;
         if (g_dut[0].rdd !== 12'h000)
            begin fails++; $display("FAIL reset_bank[%0d]: got %h expected 000", a, g_dut[0].rdd); end
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (g_dut[0].start !== 1'b0)
         begin fails++; $display("FAIL reset_idle_start: got %b expected 0", g_dut[0].start); end
   endtask

   task automatic test_basic();
      logic [2:0]  sa[$];
      logic [2:0]  rc[$];
      logic [11:0] rd[$];
      logic        sq[$];
      int          sd_alone = 0;
      do_reset(8'h05, 0);
      en = 1'b1;
      for (int c = 0; c < 200 && rc.size() < 2; c++) begin
         @(negedge clk);
         if (g_dut[0].start) sa.push_back(g_dut[0].addr);
         if (g_dut[0].rv) begin
            rc.push_back(g_dut[0].rch); rd.push_back(g_dut[0].rdat); sq.push_back(g_dut[0].sd);
         end else if (g_dut[0].sd) begin
            sd_alone++;
         end
      end
      en = 1'b0;
      tests++;
      if (rc.size() != 2 || sa.size() < 2) begin
         fails++; $display("FAIL basic_pulses: got %0d results %0d starts expected 2 and 2", rc.size(), sa.size());
         return;
      end
      tests++;
      if ({sa[0], sa[1]} !== {3'd0, 3'd2})
         begin fails++; $display("FAIL basic_addr: got %0d,%0d expected 0,2", sa[0], sa[1]); end
      tests++;
      if ({rc[0], rd[0], sq[0]} !== {3'd0, 12'h100, 1'b0})
         begin fails++; $display("FAIL basic_res0: got ch%0d %h done=%b expected ch0 100 done=0", rc[0], rd[0], sq[0]); end
      tests++;
      if ({rc[1], rd[1], sq[1]} !== {3'd2, 12'h102, 1'b1})
         begin fails++; $display("FAIL basic_res1: got ch%0d %h done=%b expected ch2 102 done=1", rc[1], rd[1], sq[1]); end
      tests++;
      if (sd_alone != 0)
         begin fails++; $display("FAIL basic_done_alone: got %0d expected 0", sd_alone); end
      rd_addr = 3'd2;
      #1;
      tests++;
      if (g_dut[0].rdd !== 12'h102)
         begin fails++; $display("FAIL basic_bank2: got %h expected 102", g_dut[0].rdd); end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_average();
      logic        got = 1'b0;
      logic [11:0] prev = '0;
      do_reset(8'h20, 1);
      rd_addr = 3'd5;
      en = 1'b1;
      for (int c = 0; c < 300 && !got; c++) begin
         prev = g_dut[1].rdd;
         @(negedge clk);
         got = g_dut[1].rv;
      end
      tests++;
      if (!got) begin fails++; $display("FAIL avg4_result: no RES_VALID within 300 cycles"); return; end
      tests++;
      if ({g_dut[1].rch, g_dut[1].rdat, g_dut[1].sd} !== {3'd5, 12'd11, 1'b1})
         begin fails++; $display("FAIL avg4_value: got ch%0d %0d done=%b expected ch5 11 done=1",
            g_dut[1].rch, g_dut[1].rdat, g_dut[1].sd); end
      tests++;
      if (g_dut[1].sc[5] != 4)
         begin fails++; $display("FAIL avg4_starts: got %0d expected 4", g_dut[1].sc[5]); end
      tests++;
      if ({prev, g_dut[1].rdd} !== {12'd0, 12'd11})
         begin fails++; $display("FAIL avg4_bank_timing: got old %h new %h expected 000 00b", prev, g_dut[1].rdd); end
      en = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_avg_full_scale();
      logic        got = 1'b0;
      logic [11:0] prev = '0;
      do_reset(8'h20, 2);
      rd_addr = 3'd5;
      en = 1'b1;
      for (int c = 0; c < 300 && !got; c++) begin
         prev = g_dut[2].rdd;
         @(negedge clk);
         got = g_dut[2].rv;
      end
      tests++;
      if (!got) begin fails++; $display("FAIL avg16_result: no RES_VALID within 300 cycles"); return; end
      tests++;
      if ({g_dut[2].rch, g_dut[2].rdat} !== {3'd5, 12'hFFF})
         begin fails++; $display("FAIL avg16_value: got ch%0d %h expected ch5 fff", g_dut[2].rch, g_dut[2].rdat); end
      tests++;
      if (g_dut[2].sc[5] != 16)
         begin fails++; $display("FAIL avg16_starts: got %0d expected 16", g_dut[2].sc[5]); end
      tests++;
      if ({prev, g_dut[2].rdd} !== {12'h000, 12'hFFF})
         begin fails++; $display("FAIL avg16_bank: got old %h new %h expected 000 fff", prev, g_dut[2].rdd); end
      en = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_timeout();
      logic seen = 1'b0;
      logic rv_seen = 1'b0;
      int   n = 0;
      do_reset(8'h18, 0);
      stall = 1'b1;
      en = 1'b1;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         seen = g_dut[0].start;
      end
      tests++;
      if (!seen || g_dut[0].addr !== 3'd3)
         begin fails++; $display("FAIL tmo_start: seen=%b addr=%0d expected 1 and 3", seen, g_dut[0].addr); end
      // ERR is registered: it shows one cycle after the TIMEOUT-th cycle counted from START.
      for (int c = 1; c <= 200 && n == 0; c++) begin
         @(negedge clk);
         if (g_dut[0].rv) rv_seen = 1'b1;
         if (g_dut[0].err) n = c;
      end
      tests++;
      if (n != TMO + 1)
         begin fails++; $display("FAIL tmo_latency: got %0d cycles expected %0d", n, TMO + 1); end
      tests++;
      if ({g_dut[0].errch, rv_seen} !== {3'd3, 1'b0})
         begin fails++; $display("FAIL tmo_flags: got err_ch=%0d rv_seen=%b expected 3 0", g_dut[0].errch, rv_seen); end
      stall = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         seen = g_dut[0].rv;
      end
      tests++;
      if (!seen || {g_dut[0].rch, g_dut[0].rdat, g_dut[0].sd, g_dut[0].err} !== {3'd4, 12'h104, 1'b1, 1'b1})
         begin fails++; $display("FAIL tmo_continue: seen=%b ch%0d %h done=%b err=%b expected ch4 104 done=1 err=1",
            seen, g_dut[0].rch, g_dut[0].rdat, g_dut[0].sd, g_dut[0].err); end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      tests++;
      if ({g_dut[0].err, g_dut[0].errch} !== {1'b0, 3'd3})
         begin fails++; $display("FAIL tmo_clear: got err=%b err_ch=%0d expected 0 3", g_dut[0].err, g_dut[0].errch); end
      en = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_en_drop();
      logic seen = 1'b0;
      int   ns = 0;
      int   bad = 0;
      do_reset(8'h02, 0);
      rd_addr = 3'd1;
      en = 1'b1;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         seen = g_dut[3].rv;
      end
      tests++;
      if (!seen || g_dut[3].rdat !== 12'h101)
         begin fails++; $display("FAIL endrop_first: seen=%b got %h expected 101", seen, g_dut[3].rdat); end
      for (int c = 0; c < 200 && ns < 2; c++) begin
         @(negedge clk);
         if (g_dut[3].start) ns++;
      end
      @(negedge clk);
      tests++;
      if (ns != 2 || g_dut[3].busy !== 1'b1)
         begin fails++; $display("FAIL endrop_inflight: starts=%0d busy=%b expected 2 1", ns, g_dut[3].busy); end
      en = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (g_dut[3].start || g_dut[3].rv || g_dut[3].sd) bad++;
      end
      tests++;
      if ({bad == 0, g_dut[3].busy} !== {1'b1, 1'b0})
         begin fails++; $display("FAIL endrop_quiet: got %0d pulses busy=%b expected 0 0", bad, g_dut[3].busy); end
      tests++;
      if (g_dut[3].rdd !== 12'h101)
         begin fails++; $display("FAIL endrop_bank: got %h expected 101", g_dut[3].rdd); end
      en = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = g_dut[3].start;
      end
      tests++;
      if (!seen || g_dut[3].addr !== 3'd1)
         begin fails++; $display("FAIL endrop_restart: seen=%b addr=%0d expected 1 1", seen, g_dut[3].addr); end
      en = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_mask();
      logic       seen = 1'b0;
      int         ns = 0;
      logic [2:0] rc[$];
      logic       sq[$];
      do_reset(8'h00, 0);
      en = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (g_dut[0].start) ns++;
      end
      tests++;
      if (ns != 0) begin fails++; $display("FAIL mask_empty: got %0d starts expected 0", ns); end
      ch_mask = 8'h81;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = g_dut[0].start;
      end
      ch_mask = 8'h01;
      tests++;
      if (!seen || g_dut[0].addr !== 3'd0)
         begin fails++; $display("FAIL mask_first: seen=%b addr=%0d expected 1 0", seen, g_dut[0].addr); end
      for (int c = 0; c < 400 && rc.size() < 3; c++) begin
         @(negedge clk);
         if (g_dut[0].rv) begin rc.push_back(g_dut[0].rch); sq.push_back(g_dut[0].sd); end
      end
      en = 1'b0;
      tests++;
      if (rc.size() != 3) begin
         fails++; $display("FAIL mask_results: got %0d results expected 3", rc.size());
      end else if ({rc[0], rc[1], rc[2], sq[0], sq[1], sq[2]} !== {3'd0, 3'd7, 3'd0, 1'b0, 1'b1, 1'b1}) begin
         fails++; $display("FAIL mask_sequence: got ch %0d,%0d,%0d done %b%b%b expected ch 0,7,0 done 011",
            rc[0], rc[1], rc[2], sq[0], sq[1], sq[2]);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_async_reset();
      logic seen = 1'b0;
      do_reset(8'h04, 0);
      rd_addr = 3'd2;
      en = 1'b1;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         seen = g_dut[0].rv;
      end
      tests++;
      if (!seen || g_dut[0].rdd !== 12'h102)
         begin fails++; $display("FAIL arst_prefill: seen=%b bank2=%h expected 1 102", seen, g_dut[0].rdd); end
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         seen = g_dut[0].start;
      end
      repeat (2) @(negedge clk);
      tests++;
      if (!seen || g_dut[0].busy !== 1'b1)
         begin fails++; $display("FAIL arst_inflight: seen=%b busy=%b expected 1 1", seen, g_dut[0].busy); end
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if ({g_dut[0].addr, g_dut[0].start, g_dut[0].rv, g_dut[0].rch, g_dut[0].rdat,
           g_dut[0].sd, g_dut[0].err, g_dut[0].errch, g_dut[0].rdd} !== '0)
         begin fails++; $display("FAIL arst_clear: addr=%0d rch=%0d rdat=%h bank2=%h expected all 0",
            g_dut[0].addr, g_dut[0].rch, g_dut[0].rdat, g_dut[0].rdd); end
      ch_mask = 8'h0C;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = g_dut[0].start;
      end
      tests++;
      if (!seen || g_dut[0].addr !== 3'd2)
         begin fails++; $display("FAIL arst_restart: seen=%b addr=%0d expected 1 2", seen, g_dut[0].addr); end
      en = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_average();
      test_avg_full_scale();
      test_timeout();
      test_en_drop();
      test_mask();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
